// File: rtl/clock_disp_pkg.sv
// Shared constants for the six-digit multiplexed 7-segment scanner.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package clock_disp_pkg;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [2:0] DIG_S0 = 3'd0;
  localparam logic [2:0] DIG_S1 = 3'd1;
  localparam logic [2:0] DIG_M0 = 3'd2;
  localparam logic [2:0] DIG_M1 = 3'd3;
  localparam logic [2:0] DIG_H0 = 3'd4;
  localparam logic [2:0] DIG_H1 = 3'd5;

  localparam logic [5:0] AN_OFF = 6'h3F;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
    logic [3:0] s1;
    logic [3:0] s0;
  } time_snap_t;

  function automatic logic [5:0] an_sel(input logic [2:0] idx);
    an_sel = ~(6'b000001 << idx);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-low 7-segment pattern; values above 9 show a dash.
module bcd_to_seg7
  import clock_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit common-anode scanner: per-frame time snapshot, inter-digit
// blanking, colon on even seconds and whole-display alarm blink.
module clock_display_scan
  import clock_disp_pkg::*;
#(
  parameter int DIGIT_CYCLES = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       disp_en,
  input  logic       Alarm,
  input  logic [1:0] H_in1,
  input  logic [3:0] H_in0,
  input  logic [3:0] M_in1,
  input  logic [3:0] M_in0,
  input  logic [3:0] S_in1,
  input  logic [3:0] S_in0,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  time_snap_t    r_shadow;
  logic [FW-1:0] r_frame;
  logic          r_blink;
  logic [5:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic       w_slot_end;
  logic       w_frame_end;
  logic       w_on;
  logic       w_blank5;
  logic       w_colon;
  logic [3:0] w_digit;
  logic [6:0] w_dec;

  assign w_slot_end  = (r_cnt == CW'(DIGIT_CYCLES - 1));
  assign w_frame_end = w_slot_end && (r_idx == DIG_H1);

  always_comb begin
    w_digit = 4'd0;
    case (r_idx)
      DIG_S0:  w_digit = r_shadow.s0;
      DIG_S1:  w_digit = r_shadow.s1;
      DIG_M0:  w_digit = r_shadow.m0;
      DIG_M1:  w_digit = r_shadow.m1;
      DIG_H0:  w_digit = r_shadow.h0;
      DIG_H1:  w_digit = {2'b00, r_shadow.h1};
      default: w_digit = 4'd0;
    endcase
  end

  bcd_to_seg7 u_dec (
    .i_bcd (w_digit),
    .o_seg (w_dec)
  );

  assign w_on = (r_cnt >= CW'(BLANK_CYCLES)) && disp_en && r_blink;

  assign w_blank5 = (r_idx == DIG_H1) && (r_shadow.h1 == 2'd0);

  assign w_colon = ((r_idx == DIG_H0) || (r_idx == DIG_M0))
                && !r_shadow.s0[0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
      r_idx <= DIG_S0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= (r_idx == DIG_H1) ? DIG_S0 : r_idx + 3'd1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Snapshot taken on the frame's last cycle so the next frame is coherent
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_shadow <= '0;
    end else if (w_frame_end) begin
      r_shadow <= '{h1: H_in1, h0: H_in0,
                    m1: M_in1, m0: M_in0,
                    s1: S_in1, s0: S_in0};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_frame <= '0;
      r_blink <= 1'b1;
    end else if (!Alarm) begin
      r_frame <= '0;
      r_blink <= 1'b1;
    end else if (w_frame_end) begin
      if (r_frame == FW'(BLINK_FRAMES - 1)) begin
        r_frame <= '0;
        r_blink <= ~r_blink;
      end else begin
        r_frame <= r_frame + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else if (w_on) begin
      r_an  <= an_sel(r_idx);
      r_seg <= w_blank5 ? SEG_BLANK : w_dec;
      r_dp  <= ~w_colon;
    end else begin
      r_an  <= AN_OFF;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: tb/tb_clock_display_scan.sv
// Scoreboard bench for clock_display_scan: stimulus queues expected
// per-cycle outputs, a negedge monitor pops and compares them.
module tb_clock_display_scan;

  localparam logic [6:0] P0 = 7'h40;
  localparam logic [6:0] P1 = 7'h79;
  localparam logic [6:0] P2 = 7'h24;
  localparam logic [6:0] P3 = 7'h30;
  localparam logic [6:0] P4 = 7'h19;
  localparam logic [6:0] P5 = 7'h12;
  localparam logic [6:0] P6 = 7'h02;
  localparam logic [6:0] P7 = 7'h78;
  localparam logic [6:0] P9 = 7'h10;
  localparam logic [6:0] PD = 7'h3F;
  localparam logic [6:0] PB = 7'h7F;

  logic       clk = 1'b0;
  logic       reset;
  logic       disp_en;
  logic       Alarm;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0, S_in1, S_in0;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;

  clock_display_scan #(
    .DIGIT_CYCLES (8),
    .BLANK_CYCLES (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .disp_en (disp_en),
    .Alarm   (Alarm),
    .H_in1   (H_in1),
    .H_in0   (H_in0),
    .M_in1   (M_in1),
    .M_in0   (M_in0),
    .S_in1   (S_in1),
    .S_in0   (S_in0),
    .seg     (seg),
    .dp      (dp),
    .an      (an)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] exp_seg [6];
  logic       exp_cn;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc || an !== e.an || seg !== e.seg || dp !== e.dp) begin
        errors++;
        $display("FAIL %s cyc=%0d/%0d got an=%h seg=%h dp=%b want an=%h seg=%h dp=%b",
                 e.nm, cyc, e.cyc, an, seg, dp, e.an, e.seg, e.dp);
      end
    end
  end

  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic set_time(input logic [1:0] h1, input logic [3:0] h0,
                          input logic [3:0] m1, input logic [3:0] m0,
                          input logic [3:0] s1, input logic [3:0] s0);
    H_in1 = h1; H_in0 = h0;
    M_in1 = m1; M_in0 = m0;
    S_in1 = s1; S_in0 = s0;
  endtask

  task automatic set_exp(input logic [6:0] d0, input logic [6:0] d1,
                         input logic [6:0] d2, input logic [6:0] d3,
                         input logic [6:0] d4, input logic [6:0] d5,
                         input logic cn);
    exp_seg[0] = d0; exp_seg[1] = d1; exp_seg[2] = d2;
    exp_seg[3] = d3; exp_seg[4] = d4; exp_seg[5] = d5;
    exp_cn = cn;
  endtask

  task automatic push_off(input int c, input string nm);
    exp_t e;
    e.cyc = c; e.an = 6'h3F; e.seg = PB; e.dp = 1'b1; e.nm = nm;
    q.push_back(e);
  endtask

  // Offsets off_lo..off_hi of the frame are expected dark.
  task automatic push_frame(input int base, input int f, input int k_end,
                            input int off_lo, input int off_hi,
                            input string nm);
    for (int k = 0; k <= k_end; k++) begin
      exp_t e;
      int   idx;
      int   cnt;
      idx = k / 8;
      cnt = k % 8;
      e.cyc = base + f * 48 + k;
      e.nm  = nm;
      if (cnt < 2 || (k >= off_lo && k <= off_hi)) begin
        e.an = 6'h3F; e.seg = PB; e.dp = 1'b1;
      end else begin
        e.an  = ~(6'b000001 << idx);
        e.seg = exp_seg[idx];
        e.dp  = (idx == 2 || idx == 4) ? exp_cn : 1'b1;
      end
      q.push_back(e);
    end
  endtask

  initial begin
    int b;
    int b2;
    reset = 1'b0; disp_en = 1'b1; Alarm = 1'b0;
    set_time(2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    for (int c = 2; c <= 4; c++) push_off(c, "reset_state");
    b = 5;
    set_exp(P0, P0, P0, P0, P0, PB, 1'b0);
    push_frame(b, 0, 47, -1, -1, "f0_zero_shadow");
    set_exp(P6, P5, P4, P3, P2, P1, 1'b0);
    push_frame(b, 1, 47, -1, -1, "f1_123456");
    at(4);
    reset = 1'b1;

    at(b + 48 + 24);
    set_time(2'd0, 4'd9, 4'd0, 4'd5, 4'd0, 4'd7);
    set_exp(P7, P0, P5, P0, P9, PB, 1'b1);
    push_frame(b, 2, 47, -1, -1, "f2_090507");

    at(b + 96 + 24);
    set_time(2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    set_exp(P6, P5, P4, P3, P2, P1, 1'b0);
    push_frame(b, 3, 47, -1, -1, "f3_m0_old");

    at(b + 144 + 24);
    M_in0 = 4'd5;
    set_exp(P6, P5, P5, P3, P2, P1, 1'b0);
    push_frame(b, 4, 47, -1, -1, "f4_m0_new");

    at(b + 192 + 24);
    S_in0 = 4'hC;
    set_exp(PD, P5, P5, P3, P2, P1, 1'b0);
    push_frame(b, 5, 47, -1, -1, "f5_dash");

    at(b + 287);
    Alarm = 1'b1;
    push_frame(b, 6, 47, -1, -1, "blink_on_a");
    push_frame(b, 7, 47, -1, -1, "blink_on_a");
    push_frame(b, 8, 47, 0, 47, "blink_off_a");
    push_frame(b, 9, 47, 0, 47, "blink_off_a");
    push_frame(b, 10, 47, -1, -1, "blink_on_b");
    push_frame(b, 11, 47, -1, -1, "blink_on_b");
    push_frame(b, 12, 47, 0, 47, "blink_off_b");
    push_frame(b, 13, 47, 0, 23, "alarm_drop");
    push_frame(b, 14, 47, 12, 14, "disp_en_gap");
    push_frame(b, 15, 23, 21, 23, "mid_reset");
    b2 = b + 744;
    set_exp(P0, P0, P0, P0, P0, PB, 1'b0);
    push_frame(b2, 0, 47, -1, -1, "post_reset");

    at(b + 646);
    Alarm = 1'b0;
    at(b + 683);
    disp_en = 1'b0;
    at(b + 686);
    disp_en = 1'b1;
    at(b + 740);
    reset = 1'b0;
    at(b + 743);
    reset = 1'b1;

    for (int i = 0; i < 300 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
